// File: rtl/rsa_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rsa_job_arbiter
// Description : Round-robin job scheduler sharing one streaming RSA/Montgomery
//               engine among NREQ requesters. Grants one requester per job,
//               pulses the engine start, forwards IN_WORDS operands, returns
//               OUT_WORDS results and releases the grant. A watchdog aborts
//               jobs that stop handshaking.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_job_arbiter #(
    parameter int FDW       = 32,
    parameter int NREQ      = 4,
    parameter int IN_WORDS  = 64,
    parameter int OUT_WORDS = 64,
    parameter int CW        = 8,
    parameter int TMO_CYC   = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [NREQ-1:0]     req,
    output logic [NREQ-1:0]     gnt,
    input  logic [NREQ-1:0]     req_vld,
    input  logic [NREQ*FDW-1:0] req_din,
    output logic [NREQ-1:0]     req_rdy,
    output logic [NREQ-1:0]     resp_vld,
    output logic [FDW-1:0]      resp_dout,
    input  logic [NREQ-1:0]     resp_rdy,
    output logic [NREQ-1:0]     done,
    output logic                err,
    output logic [2:0]          err_id,
    output logic                eng_start,
    input  logic                eng_rdy,
    output logic                eng_vld,
    output logic [FDW-1:0]      eng_din,
    output logic                eng_out_rdy,
    input  logic                eng_out_vld,
    input  logic [FDW-1:0]      eng_out_dout
);

    // Watchdog counter is wide enough to hold TMO_CYC-1 for any TMO_CYC
    localparam int            c_wdw      = $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] c_in_last  = CW'(IN_WORDS - 1);
    localparam logic [CW-1:0] c_out_last = CW'(OUT_WORDS - 1);
    localparam logic [c_wdw-1:0] c_wd_last = c_wdw'(TMO_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_g;
    logic [2:0]       r_ptr;
    logic [2:0]       w_win;
    logic             w_found;
    logic [CW-1:0]    r_cnt;
    logic [c_wdw-1:0] r_wd;
    logic [NREQ-1:0]  w_gsel;
    logic             w_sel_vld;
    logic             w_sel_resp_rdy;
    logic [FDW-1:0]   w_sel_din;
    logic             w_xfer_in;
    logic             w_xfer_out;
    logic             w_abort;
    logic             w_clear;

    // clr behaves exactly like rst
    assign w_clear = rst | clr;

    // Decode the granted index into a one-hot mask and select its streams
    always_comb begin
        w_gsel         = '0;
        w_sel_vld      = 1'b0;
        w_sel_resp_rdy = 1'b0;
        w_sel_din      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_g == 3'(i)) begin
                w_gsel[i]      = 1'b1;
                w_sel_vld      = req_vld[i];
                w_sel_resp_rdy = resp_rdy[i];
                w_sel_din      = req_din[i*FDW +: FDW];
            end
        end
    end

    // Round-robin pick: first requester set, scanning upward from ptr+1 with wrap
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_found && req[i] && (((int'(r_ptr) + k) % NREQ) == i)) begin
                    w_found = 1'b1;
                    w_win   = 3'(i);
                end
            end
        end
    end

    // Next-state logic and all outputs; everything is zero outside a job
    always_comb begin
        w_state_nxt = r_state;
        w_xfer_in   = 1'b0;
        w_xfer_out  = 1'b0;
        w_abort     = 1'b0;
        gnt         = '0;
        req_rdy     = '0;
        resp_vld    = '0;
        resp_dout   = '0;
        done        = '0;
        err         = 1'b0;
        err_id      = '0;
        eng_start   = 1'b0;
        eng_vld     = 1'b0;
        eng_din     = '0;
        eng_out_rdy = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                gnt         = w_gsel;
                eng_start   = 1'b1;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                gnt       = w_gsel;
                eng_vld   = w_sel_vld;
                eng_din   = w_sel_din;
                req_rdy   = w_gsel & {NREQ{eng_rdy}};
                w_xfer_in = w_sel_vld & eng_rdy;
                if (w_xfer_in) begin
                    if (r_cnt == c_in_last) begin
                        w_state_nxt = S_DRAIN;
                    end
                end else if (r_wd == c_wd_last) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                gnt         = w_gsel;
                eng_out_rdy = w_sel_resp_rdy;
                resp_vld    = w_gsel & {NREQ{eng_out_vld}};
                resp_dout   = eng_out_dout;
                w_xfer_out  = eng_out_vld & w_sel_resp_rdy;
                if (w_xfer_out) begin
                    if (r_cnt == c_out_last) begin
                        w_state_nxt = S_DONE;
                    end
                end else if (r_wd == c_wd_last) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                gnt         = w_gsel;
                done        = w_gsel;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // An abort releases the grant next cycle and never produces done
        if (w_abort) begin
            err    = 1'b1;
            err_id = r_g;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Granted index and round-robin pointer, updated only on an IDLE decision
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_g   <= '0;
            r_ptr <= 3'(NREQ - 1);
        end else if ((r_state == S_IDLE) && w_found) begin
            r_g   <= w_win;
            r_ptr <= w_win;
        end
    end

    // Word counter and watchdog; both restart on every state change
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_cnt <= '0;
            r_wd  <= '0;
        end else begin
            if (r_state != w_state_nxt) begin
                r_cnt <= '0;
            end else if (w_xfer_in || w_xfer_out) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if ((r_state != w_state_nxt) || w_xfer_in || w_xfer_out) begin
                r_wd <= '0;
            end else if ((r_state == S_LOAD) || (r_state == S_DRAIN)) begin
                r_wd <= r_wd + c_wdw'(1);
            end else begin
                r_wd <= '0;
            end
        end
    end

endmodule
`default_nettype wire
